// File: rtl/park_pkg.sv
// park_pkg: shared mode enum, rounding constant and saturation helper for the Park rotator.
package park_pkg;
  typedef enum logic {PARK_INV, PARK_FWD} park_mode_e;
  localparam int MAX_W = 64;
  typedef logic signed [2*MAX_W:0] wide_t;
  function automatic wide_t rnd_const(input int q);
    return wide_t'(1) <<< (q - 1);
  endfunction
  // Clip v into the signed range of a w-bit word; ~hi is the most negative value.
  function automatic wide_t saturate(input wide_t v, input int w);
    wide_t hi;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    return v > hi ? hi : v < ~hi ? ~hi : v;
  endfunction
endpackage

// File: rtl/park_rotator_if.sv
// park_rotator_if: sample/result stream handshake bundle of the Park rotator.
interface park_rotator_if #(
  parameter int D_WIDTH = 32,
  parameter int CH_W = 2
);
  logic in_valid, in_ready, in_mode;
  logic [CH_W-1:0] in_ch;
  logic signed [D_WIDTH-1:0] in_x, in_y, in_sin, in_cos;
  logic out_valid, out_ready, out_sat;
  logic [CH_W-1:0] out_ch;
  logic signed [D_WIDTH-1:0] out_a, out_b;
  modport master(
    output in_valid, in_mode, in_ch, in_x, in_y, in_sin, in_cos, out_ready,
    input in_ready, out_valid, out_ch, out_a, out_b, out_sat
  );
  modport slave(
    input in_valid, in_mode, in_ch, in_x, in_y, in_sin, in_cos, out_ready,
    output in_ready, out_valid, out_ch, out_a, out_b, out_sat
  );
endinterface

// File: rtl/park_lane.sv
// park_lane: one output lane, p0 +/- p1 with rounding (S2) then shift and saturate (S3).
module park_lane import park_pkg::*; #(
  parameter int D_WIDTH = 32,
  parameter int Q_BITS = 10
)(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sub,
  input  logic signed [2*D_WIDTH-1:0] p0,
  input  logic signed [2*D_WIDTH-1:0] p1,
  output logic signed [D_WIDTH-1:0] y,
  output logic sat
);
  localparam int SW = 2*D_WIDTH + 1;
  logic signed [SW-1:0] e0, e1, sum_q, shifted;
  wide_t clip;
  always_comb begin
    e0 = p0;
    e1 = p1;
    shifted = sum_q >>> Q_BITS;
    clip = saturate(wide_t'(shifted), D_WIDTH);
  end
  always_ff @(posedge clk)
    if (rst) begin
      sum_q <= '0;
      y <= '0;
      sat <= 1'b0;
    end else if (en) begin
      sum_q <= (sub ? e0 - e1 : e0 + e1) + SW'(rnd_const(Q_BITS));
      y <= clip[D_WIDTH-1:0];
      sat <= clip != wide_t'(shifted);
    end
endmodule

// File: rtl/park_rotator.sv
// park_rotator: pipelined inverse/forward Park rotation with channel tags,
// global-enable backpressure and per-channel sticky saturation flags.
module park_rotator import park_pkg::*; #(
  parameter int D_WIDTH = 32,
  parameter int Q_BITS = 10,
  parameter int NUM_CH = 4
)(
  input  logic clk,
  input  logic rst,
  park_rotator_if.slave bus,
  input  logic sat_clr,
  output logic [NUM_CH-1:0] sat_sticky
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int PW = 2*D_WIDTH;
  logic en, v1, v2, v3, sat_a, sat_b;
  park_mode_e mode1;
  logic [CH_W-1:0] ch1, ch2;
  logic signed [PW-1:0] p_xc, p_ys, p_xs, p_yc;
  logic [NUM_CH-1:0] set_vec;
  always_comb begin
    en = ~v3 | bus.out_ready;
    set_vec = '0;
    for (int i = 0; i < NUM_CH; i++)
      set_vec[i] = v3 && bus.out_ready && bus.out_sat && bus.out_ch == CH_W'(i);
  end
  assign bus.in_ready = en;
  assign bus.out_valid = v3;
  assign bus.out_sat = sat_a | sat_b;
  always_ff @(posedge clk)
    if (rst) begin
      {v1, v2, v3} <= '0;
      mode1 <= PARK_INV;
      {ch1, ch2, bus.out_ch} <= '0;
      {p_xc, p_ys, p_xs, p_yc} <= '0;
      sat_sticky <= '0;
    end else begin
      sat_sticky <= (sat_clr ? '0 : sat_sticky) | set_vec;
      if (en) begin
        v1 <= bus.in_valid;
        v2 <= v1;
        v3 <= v2;
        mode1 <= park_mode_e'(bus.in_mode);
        ch1 <= bus.in_ch;
        ch2 <= ch1;
        bus.out_ch <= ch2;
        p_xc <= PW'(bus.in_x) * PW'(bus.in_cos);
        p_ys <= PW'(bus.in_y) * PW'(bus.in_sin);
        p_xs <= PW'(bus.in_x) * PW'(bus.in_sin);
        p_yc <= PW'(bus.in_y) * PW'(bus.in_cos);
      end
    end
  // Inverse: a = xc - ys, b = yc + xs.  Forward: a = xc + ys, b = yc - xs.
  park_lane #(.D_WIDTH(D_WIDTH), .Q_BITS(Q_BITS)) u_lane_a (
    .clk, .rst, .en, .sub(mode1 == PARK_INV), .p0(p_xc), .p1(p_ys), .y(bus.out_a), .sat(sat_a)
  );
  park_lane #(.D_WIDTH(D_WIDTH), .Q_BITS(Q_BITS)) u_lane_b (
    .clk, .rst, .en, .sub(mode1 == PARK_FWD), .p0(p_yc), .p1(p_xs), .y(bus.out_b), .sat(sat_b)
  );
endmodule
